timer_apb_arbiter: RTL

- Shares the timer's single 8-bit APB register port between two requesters: m0 (CPU) and m1 (DMA/debug).
- Accepts simple req/done commands, arbitrates round-robin, and runs the APB SETUP/ACCESS sequence toward the timer.
- Returns read data and error to the winning requester.
- Sits between the bus masters and the timer register block (TCR at 0x01, etc.).

---
 rtl/timer_bus_pkg.sv | 19 +
 rtl/timer_apb_arbiter_rr_arb2.sv | 32 +++
 rtl/timer_apb_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/timer_bus_pkg.sv
// Shared definitions for the timer APB register port: default widths, FSM
// state encoding, master indices and timer register addresses.
package timer_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [7:0] TCR = 8'h01;

endpackage

// File: rtl/timer_apb_arbiter_rr_arb2.sv
// Two-way round-robin grant: pointer register plus a mask for the master
// whose done pulse is currently out, so its stale req cannot re-win.
module rr_arb2
  import timer_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       mask_en,
  input  logic       mask_idx,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic       ptr;
  logic [1:0] eligible;

  always_comb begin
    eligible[0] = req[0] && !(mask_en && (mask_idx == M0));
    eligible[1] = req[1] && !(mask_en && (mask_idx == M1));
    gnt_valid   = |eligible;
    if (&eligible) gnt_idx = ptr;
    else           gnt_idx = eligible[1] ? M1 : M0;
  end

  always_ff @(posedge clk) begin
    if (rst)                    ptr <= M0;
    else if (take && gnt_valid) ptr <= ~gnt_idx;
  end

endmodule

// File: rtl/timer_apb_arbiter.sv
// Arbitrates two req/done masters onto the timer's APB register port.
// Optional APB_TIMEOUT_EN: forces an error completion after TIMEOUT_CYC ACCESS waits.
module timer_apb_arbiter
  import timer_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        state, state_nx;
  logic              owner;
  logic              gnt_valid, gnt_idx, grant;
  logic              timeout, xfer_end;
  logic              psel_nx, penable_nx, m0_done_nx, m1_done_nx, err_nx;
  logic [DATA_W-1:0] rdata_nx;

  assign grant    = (state == ST_IDLE) && gnt_valid;
  assign xfer_end = (state == ST_ACCESS) && (pready || timeout);

  rr_arb2 u_arb (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .req       ({m1_req, m0_req}),
    .mask_en   (m0_done || m1_done),
    .mask_idx  (owner),
    .take      (grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state != ST_ACCESS) wait_cnt <= '0;
    else if (!pready)                  wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the wait cycle whose increment would reach TIMEOUT_CYC.
  assign timeout = (state == ST_ACCESS) && !pready &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  // ACCESS waits for pready indefinitely; TIMEOUT_CYC has no effect here.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (grant) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (xfer_end) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    psel_nx    = (state_nx != ST_IDLE);
    penable_nx = (state_nx == ST_ACCESS);
    m0_done_nx = xfer_end && (owner == M0);
    m1_done_nx = xfer_end && (owner == M1);
    err_nx     = 1'b0;
    rdata_nx   = '0;
    if (xfer_end) begin
      if (pready) begin
        err_nx = pslverr;
        if (!pwrite) rdata_nx = prdata;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      owner    <= M0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      m0_done  <= 1'b0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_done  <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else begin
      psel     <= psel_nx;
      penable  <= penable_nx;
      m0_done  <= m0_done_nx;
      m0_rdata <= m0_done_nx ? rdata_nx : '0;
      m0_err   <= m0_done_nx && err_nx;
      m1_done  <= m1_done_nx;
      m1_rdata <= m1_done_nx ? rdata_nx : '0;
      m1_err   <= m1_done_nx && err_nx;
      if (grant) begin
        owner  <= gnt_idx;
        pwrite <= (gnt_idx == M1) ? m1_write : m0_write;
        paddr  <= (gnt_idx == M1) ? m1_addr  : m0_addr;
        pwdata <= (gnt_idx == M1) ? m1_wdata : m0_wdata;
      end
    end
  end

endmodule
